// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the byte-stream boot loader.
package boot_loader_pkg;

    // Bytes in the little-endian word-count header (and in every data word).
    localparam int unsigned HDR_BYTES = 4;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StHdr   = 3'd1,
        StData  = 3'd2,
        StWrite = 3'd3,
        StDone  = 3'd4,
        StErr   = 3'd5
    } state_t;

endpackage

// File: rtl/word_assembler.sv
// Collects four little-endian bytes into a 32-bit word.
// The word output already includes the byte being loaded this cycle, so the
// loader can act on the complete word in the same cycle as the 4th byte.
module word_assembler
    import boot_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        load,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        last_byte
);

    logic [1:0]  r_cnt;
    logic [31:0] r_word;
    logic [31:0] w_word;

    // Merge the incoming byte into lane r_cnt of the stored partial word.
    always_comb begin
        w_word = r_word;
        if (load) begin
            w_word[{r_cnt, 3'b000} +: 8] = byte_in;
        end
    end

    // Byte counter wraps 3->0; partial bytes are held while load is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt  <= 2'd0;
            r_word <= 32'd0;
        end else if (clear) begin
            r_cnt  <= 2'd0;
            r_word <= 32'd0;
        end else if (load) begin
            r_cnt  <= r_cnt + 2'd1;
            r_word <= w_word;
        end
    end

    assign word      = w_word;
    assign last_byte = (r_cnt == 2'(HDR_BYTES - 1));

endmodule

// File: rtl/boot_loader.sv
// Streams a length-prefixed image into the unified memory, then releases the
// multicycle core from reset. The integrating level selects the memory port:
// loader outputs while core_rst_n is 0, the core's own port otherwise.
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    output logic        core_rst_n,
    output logic        done,
    output logic        err
);

    localparam logic [31:0] DepthW = 32'(DEPTH_WORDS);

    state_t      r_state;
    logic [31:0] r_idx;
    logic [31:0] r_n;
    logic        r_in_ready;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wd;
    logic        r_core_rst_n;
    logic        r_done;
    logic        r_err;

    logic        w_xfer;
    logic        w_clear;
    logic        w_last;
    logic [31:0] w_word;
    logic [31:0] w_idx_inc;

    assign w_xfer    = in_valid & r_in_ready;
    assign w_clear   = (r_state == StIdle);
    assign w_idx_inc = r_idx + 32'd1;

    word_assembler u_asm (
        .clk       (clk),
        .rst       (rst),
        .clear     (w_clear),
        .load      (w_xfer),
        .byte_in   (in_data),
        .word      (w_word),
        .last_byte (w_last)
    );

    // Loader FSM; outputs are registered and set on entry to each state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= StIdle;
            r_idx        <= 32'd0;
            r_n          <= 32'd0;
            r_in_ready   <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= 32'd0;
            r_mem_wd     <= 32'd0;
            r_core_rst_n <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;
            case (r_state)
                StIdle: begin
                    r_state    <= StHdr;
                    r_in_ready <= 1'b1;
                end
                StHdr: begin
                    if (w_xfer && w_last) begin
                        r_n <= w_word;
                        if (w_word == 32'd0) begin
                            r_state      <= StDone;
                            r_in_ready   <= 1'b0;
                            r_done       <= 1'b1;
                            r_core_rst_n <= 1'b1;
                        end else if (w_word > DepthW) begin
                            r_state    <= StErr;
                            r_in_ready <= 1'b0;
                            r_err      <= 1'b1;
                        end else begin
                            r_state <= StData;
                        end
                    end
                end
                StData: begin
                    if (w_xfer && w_last) begin
                        r_state    <= StWrite;
                        r_in_ready <= 1'b0;
                        r_mem_we   <= 1'b1;
                        r_mem_addr <= BASE_ADDR + {r_idx[29:0], 2'b00};
                        r_mem_wd   <= w_word;
                    end
                end
                StWrite: begin
                    r_idx <= w_idx_inc;
                    if (w_idx_inc == r_n) begin
                        r_state      <= StDone;
                        r_done       <= 1'b1;
                        r_core_rst_n <= 1'b1;
                    end else begin
                        r_state    <= StData;
                        r_in_ready <= 1'b1;
                    end
                end
                StDone: begin
                    r_state <= StDone;
                end
                StErr: begin
                    r_state <= StErr;
                end
                default: begin
                    r_state    <= StIdle;
                    r_in_ready <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wd     = r_mem_wd;
    assign core_rst_n = r_core_rst_n;
    assign done       = r_done;
    assign err        = r_err;

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: two instances share one byte stream and
// differ only in BASE_ADDR; writes are compared against a list model.
module tb_boot_loader;

    localparam int unsigned DEPTH = 8;
    localparam logic [31:0] BASE0 = 32'h0000_0000;
    localparam logic [31:0] BASE1 = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;

    logic        rdy0, we0, crn0, done0, err0;
    logic [31:0] addr0, wd0;
    logic        rdy1, we1, crn1, done1, err1;
    logic [31:0] addr1, wd1;

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [31:0] wa0[$];
    logic [31:0] wdq0[$];
    int          wc0[$];
    logic [31:0] wa1[$];
    logic [31:0] wdq1[$];
    int          xc[$];
    logic [31:0] g_words[$];

    boot_loader #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy0), .mem_we(we0), .mem_addr(addr0), .mem_wd(wd0),
        .core_rst_n(crn0), .done(done0), .err(err0)
    );

    boot_loader #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy1), .mem_we(we1), .mem_addr(addr1), .mem_wd(wd1),
        .core_rst_n(crn1), .done(done1), .err(err1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every memory write away from the active edge.
    always @(negedge clk) begin
        if (we0 === 1'b1) begin
            wa0.push_back(addr0);
            wdq0.push_back(wd0);
            wc0.push_back(cyc);
        end
        if (we1 === 1'b1) begin
            wa1.push_back(addr1);
            wdq1.push_back(wd1);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Assert reset off-edge, verify the asynchronous clear, then release.
    task automatic do_reset();
        in_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("rst_ctl", {54'd0, rdy0, we0, crn0, done0, err0, rdy1, we1, crn1, done1, err1},
              64'd0);
        check("rst_addr", {addr0, addr1}, 64'd0);
        check("rst_wd", {wd0, wd1}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("idle_to_hdr_ready", {62'd0, rdy0, rdy1}, 64'd3);
        wa0.delete(); wdq0.delete(); wc0.delete();
        wa1.delete(); wdq1.delete(); xc.delete();
    endtask

    // Present one byte after an optional in_valid gap; wait for the handshake.
    task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
        ok = 1'b0;
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        for (int k = 0; k < 40; k++) begin
            if (rdy0) begin
                @(posedge clk);
                #1;
                xc.push_back(cyc);
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Send header n plus its data words, then compare against the list model.
    task automatic run_stream(input logic [31:0] n, input int gap_byte, input int gap_len,
                              input bit rand_gaps, input bit exp_done, input bit exp_err,
                              input string name);
        logic [7:0]  bytes[$];
        logic [31:0] exp_w[$];
        logic [31:0] w;
        int          nw;
        int          gap;
        int          acc;
        int          flag_cyc;
        int          rdy_seen;
        bit          ok;

        for (int i = 0; i < 4; i++) bytes.push_back(n[8*i +: 8]);
        nw = exp_err ? 0 : int'(n);
        for (int i = 0; i < nw; i++) begin
            w = (i < g_words.size()) ? g_words[i] : $urandom;
            exp_w.push_back(w);
            for (int j = 0; j < 4; j++) bytes.push_back(w[8*j +: 8]);
        end

        acc = 0;
        for (int i = 0; i < bytes.size(); i++) begin
            gap = (i == gap_byte) ? gap_len : (rand_gaps ? int'($urandom_range(0, 2)) : 0);
            send_byte(bytes[i], gap, ok);
            if (!ok) break;
            acc++;
        end
        check({name, "_accepted"}, 64'(acc), 64'(bytes.size()));
        in_valid = 1'b0;

        flag_cyc = -1;
        for (int k = 0; k < 60; k++) begin
            if (done0 || err0) begin
                flag_cyc = cyc;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (xc.size() > 0)
            check({name, "_flag_cycle"}, 64'(flag_cyc), 64'(xc[xc.size()-1] + (nw > 0 ? 1 : 0)));

        if (exp_err) begin
            // A byte offered after an invalid header must never be taken.
            in_valid = 1'b1;
            in_data  = 8'hA5;
            rdy_seen = 0;
            repeat (10) begin
                @(posedge clk);
                #1;
                if (rdy0 || rdy1) rdy_seen++;
            end
            in_valid = 1'b0;
            check({name, "_err_stall"}, 64'(rdy_seen), 64'd0);
        end

        check({name, "_flags0"}, {60'd0, done0, err0, crn0, rdy0},
              {60'd0, exp_done, exp_err, exp_done, 1'b0});
        check({name, "_flags1"}, {60'd0, done1, err1, crn1, rdy1},
              {60'd0, exp_done, exp_err, exp_done, 1'b0});
        check({name, "_nwrites0"}, 64'(wa0.size()), 64'(nw));
        check({name, "_nwrites1"}, 64'(wa1.size()), 64'(nw));
        for (int i = 0; i < nw && i < wa0.size() && i < wa1.size(); i++) begin
            check($sformatf("%s_w%0d_a0", name, i), 64'(wa0[i]), 64'(BASE0 + 32'(4 * i)));
            check($sformatf("%s_w%0d_d0", name, i), 64'(wdq0[i]), 64'(exp_w[i]));
            check($sformatf("%s_w%0d_a1", name, i), 64'(wa1[i]), 64'(BASE1 + 32'(4 * i)));
            check($sformatf("%s_w%0d_d1", name, i), 64'(wdq1[i]), 64'(exp_w[i]));
            if (xc.size() > 4 + 4 * i + 3)
                check($sformatf("%s_w%0d_lat", name, i), 64'(wc0[i]), 64'(xc[4 + 4 * i + 3]));
        end
    endtask

    typedef struct {
        logic [31:0] n;
        int          gap_byte;
        int          gap_len;
        bit          rand_gaps;
        bit          exp_done;
        bit          exp_err;
    } vec_t;

    vec_t tbl[8];

    initial begin
        bit          ok;
        logic [31:0] rn;
        logic [7:0]  part[6];

        tbl[0] = '{32'd0,           -1, 0, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{32'd1,            6, 3, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{32'(DEPTH + 1),  -1, 0, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{32'(DEPTH),      -1, 0, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{32'd3,           -1, 0, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{32'hFFFF_FFFF,   -1, 0, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{32'h0000_0100,    2, 2, 1'b0, 1'b0, 1'b1};
        tbl[7] = '{32'd5,            9, 4, 1'b1, 1'b1, 1'b0};

        // Reference image: two words, in_valid held high throughout.
        do_reset();
        g_words.push_back(32'h1234_5678);
        g_words.push_back(32'hDEAD_BEEF);
        run_stream(32'd2, -1, 0, 1'b0, 1'b1, 1'b0, "n2_fixed");
        g_words.delete();

        for (int i = 0; i < 8; i++) begin
            do_reset();
            run_stream(tbl[i].n, tbl[i].gap_byte, tbl[i].gap_len, tbl[i].rand_gaps,
                       tbl[i].exp_done, tbl[i].exp_err, $sformatf("vec%0d", i));
        end

        // Reset in the middle of an N=3 load, then a fresh N=1 image.
        do_reset();
        part[0] = 8'd3; part[1] = 8'd0; part[2] = 8'd0; part[3] = 8'd0;
        part[4] = 8'h11; part[5] = 8'h22;
        for (int i = 0; i < 6; i++) send_byte(part[i], 0, ok);
        check("midload_accepted", 64'(xc.size()), 64'd6);
        do_reset();
        run_stream(32'd1, -1, 0, 1'b0, 1'b1, 1'b0, "after_midreset");

        // Random headers and random in_valid gaps.
        for (int i = 0; i < 8; i++) begin
            rn = 32'($urandom_range(0, DEPTH + 2));
            do_reset();
            run_stream(rn, -1, 0, 1'b1, (rn <= 32'(DEPTH)), (rn > 32'(DEPTH)),
                       $sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/boot_loader.md
BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: capacity of the unified memory in 32-bit words.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000: byte address of the first loaded word.
REQ-003 Port clk, input, 1: single clock; every register updates on its rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous and active-low.
REQ-005 Port in_valid, input, 1: the upstream byte source presents a byte.
REQ-006 Port in_data, input, 8: the byte presented.
REQ-007 Port in_ready, output, 1: the loader accepts a byte; a transfer occurs on a clock edge where in_valid and in_ready are both 1.
REQ-008 Port mem_we, output, 1: write enable to the unified memory port, muxed ahead of the core's MemWrite.
REQ-009 Port mem_addr, output, 32: memory byte address.
REQ-010 Port mem_wd, output, 32: memory write data.
REQ-011 Port core_rst_n, output, 1: active-low reset to the multicycle core; the core is held in reset while this is 0.
REQ-012 Port done, output, 1: the image is fully loaded.
REQ-013 Port err, output, 1: the header is invalid.

Function
REQ-014 Stream format SHALL be: a 4-byte header word count N, little-endian; then N words of 4 bytes each, little-endian (the first byte fills bits [7:0]).
REQ-015 FSM states SHALL be IDLE, HDR, DATA, WRITE, DONE, ERR.
REQ-016 IDLE SHALL go to HDR unconditionally on the first clock after reset releases.
REQ-017 in_ready SHALL be 1 only in HDR and DATA, and 0 in all other states.
REQ-018 A 2-bit byte counter SHALL increment on each transfer and wrap 3->0.
REQ-019 Each accepted byte SHALL be placed in the assembled word at lane [8*k+7:8*k], where k is the byte counter value.
REQ-020 On the 4th HDR byte, N is latched and the next state is chosen as follows:
  - N==0 -> DONE.
  - N>DEPTH_WORDS -> ERR.
  - otherwise -> DATA.
REQ-021 On the 4th DATA byte, the next state SHALL be WRITE.
REQ-022 WRITE SHALL last exactly one cycle and drive:
  - mem_we=1;
  - mem_addr=BASE_ADDR+4*idx;
  - mem_wd = the assembled word.
REQ-023 After WRITE, idx SHALL increment; if idx equals N the FSM goes to DONE, else to DATA.
REQ-024 Latency SHALL be one WRITE cycle after the cycle accepting the 4th byte; the minimum is 5 cycles per word.
REQ-025 idx SHALL be 32 bits wide; the address arithmetic is modulo 2^32.
REQ-026 In IDLE, HDR, DATA, DONE and ERR: mem_we=0, and mem_addr and mem_wd hold their last values.
REQ-027 DONE SHALL be terminal, with done=1 and core_rst_n=1.
REQ-028 ERR SHALL be terminal, with err=1 and core_rst_n=0.
REQ-029 in_valid deasserting mid-word SHALL stall with no state change; partial bytes are retained.
REQ-030 Bytes presented while in_ready=0 SHALL NOT be consumed.

Reset
REQ-031 Asserting rst at any time, including mid-load, SHALL asynchronously force the following:
  - state=IDLE; byte counter, idx and N = 0;
  - in_ready=0, mem_we=0, mem_addr=0, mem_wd=0;
  - core_rst_n=0, done=0, err=0.
REQ-032 A load interrupted by reset SHALL restart from the header; any words already written are simply overwritten.

Structure
REQ-033 Package boot_loader_pkg SHALL hold the FSM state enumeration and the constant HDR_BYTES=4.
REQ-034 Sub-module word_assembler SHALL own the byte counter and the 32-bit lane-insert register, with inputs clear and load and outputs word and last_byte.
REQ-035 The top-level integration SHALL drive the memory port from the loader while core_rst_n=0, and from the core otherwise.

Verification
REQ-036 Header N=2, then bytes 78 56 34 12 EF BE AD DE, in_valid held high -> two writes:
  - addr 0x0, data 0x12345678;
  - addr 0x4, data 0xDEADBEEF.
  Then done=1 and core_rst_n=1.
REQ-037 Header N=0 -> DONE in the cycle after the 4th header byte; no mem_we pulse.
REQ-038 Header N=DEPTH_WORDS+1 -> err=1, core_rst_n stays 0, in_ready stays 0, and no writes occur.
REQ-039 N=1, with in_valid low for 3 cycles between bytes 2 and 3 -> mem_wd still equals the correct word, and exactly one write occurs.
REQ-040 rst pulsed low after 6 bytes of an N=3 load -> all outputs are 0 asynchronously; a fresh N=1 stream then writes address 0x0 and sets done.
REQ-041 N=DEPTH_WORDS with BASE_ADDR=0x100 -> the last write is at 0x100+4*(DEPTH_WORDS-1), and done asserts.
